// File: rtl/hack_video_pkg.sv
// Shared timing defaults, screen geometry and pixel polarity for the Hack
// video read path.
package hack_video_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_X_OFFSET = 64;
  localparam int unsigned DEF_Y_OFFSET = 112;

  localparam int unsigned SCREEN_W      = 512;
  localparam int unsigned SCREEN_H      = 256;
  localparam int unsigned WORDS_PER_ROW = 32;
  localparam int unsigned WORD_BITS     = 16;
  localparam int unsigned FB_ADDR_W     = 13;

  // Counters share the framebuffer address width so address maths stays in one type.
  localparam int unsigned CNT_W = FB_ADDR_W;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    PIX_WHITE = 1'b0,
    PIX_BLACK = 1'b1
  } pixel_t;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/video_timing.sv
// Raster counters plus unregistered de/sync/screen-window flags derived from them.
module video_timing
  import hack_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned X_OFFSET = DEF_X_OFFSET,
  parameter int unsigned Y_OFFSET = DEF_Y_OFFSET
) (
  input  logic clk,
  input  logic reset_n,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic de_raw,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic win_raw,
  output logic win_row
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t X_START  = cnt_t'(X_OFFSET);
  localparam cnt_t X_END    = cnt_t'(X_OFFSET + SCREEN_W);
  localparam cnt_t Y_START  = cnt_t'(Y_OFFSET);
  localparam cnt_t Y_END    = cnt_t'(Y_OFFSET + SCREEN_H);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  always_comb begin
    de_raw    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_raw = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vsync_raw = (v_cnt >= VS_START) && (v_cnt < VS_END);
    win_row   = (v_cnt >= Y_START) && (v_cnt < Y_END);
    win_raw   = win_row && (h_cnt >= X_START) && (h_cnt < X_END);
  end

endmodule

// File: rtl/screen_scanout.sv
// Hack screen scanout: fetches framebuffer words and serialises them onto a
// VGA raster. Define SCANOUT_FRAME_COUNT_EN to add frame_count/vblank_start.
module screen_scanout
  import hack_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned X_OFFSET = DEF_X_OFFSET,
  parameter int unsigned Y_OFFSET = DEF_Y_OFFSET
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [FB_ADDR_W-1:0] fb_address,
  output logic                 fb_rd,
  input  logic [WORD_BITS-1:0] fb_data,
  output logic                 pixel,
  output logic                 de,
  output logic                 hsync_n,
  output logic                 vsync_n
`ifdef SCANOUT_FRAME_COUNT_EN
  ,
  output logic [15:0]          frame_count,
  output logic [0:0]           vblank_start
`endif
);

  localparam cnt_t X_START = cnt_t'(X_OFFSET);
  localparam cnt_t X_END   = cnt_t'(X_OFFSET + SCREEN_W);
  localparam cnt_t Y_START = cnt_t'(Y_OFFSET);

  cnt_t h_cnt, v_cnt;
  logic de_raw, hsync_raw, vsync_raw, win_raw, win_row;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .X_OFFSET (X_OFFSET),
    .Y_OFFSET (Y_OFFSET)
  ) u_timing (
    .clk       (clk),
    .reset_n   (reset_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .de_raw    (de_raw),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .win_raw   (win_raw),
    .win_row   (win_row)
  );

  // fb_rd is registered, so decide it from h_cnt+2: the strobe then lands on
  // h_cnt == X_OFFSET+16k-1 and data arrives for the load at X_OFFSET+16k.
  cnt_t h_ahead, fetch_off, row_off, next_addr;
  logic fetch_next;
  logic load;
  logic [WORD_BITS-1:0] shreg;

  always_comb begin
    h_ahead    = h_cnt + cnt_t'(2);
    fetch_off  = h_ahead - X_START;
    row_off    = v_cnt - Y_START;
    next_addr  = row_off * cnt_t'(WORDS_PER_ROW) + (fetch_off >> 4);
    fetch_next = win_row && (h_ahead >= X_START) && (h_ahead < X_END)
                 && (h_ahead[3:0] == 4'd0);
    // X_OFFSET is a multiple of 16, so word boundaries align with h_cnt[3:0].
    load       = win_raw && (h_cnt[3:0] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fb_rd      <= 1'b0;
      fb_address <= '0;
      pixel      <= PIX_WHITE;
      de         <= 1'b0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      shreg      <= '0;
    end else begin
      fb_rd   <= fetch_next;
      de      <= de_raw;
      hsync_n <= ~hsync_raw;
      vsync_n <= ~vsync_raw;
      if (fetch_next) begin
        fb_address <= next_addr;
      end
      if (load) begin
        pixel <= fb_data[0];
        shreg <= {1'b0, fb_data[WORD_BITS-1:1]};
      end else if (win_raw) begin
        pixel <= shreg[0];
        shreg <= {1'b0, shreg[WORD_BITS-1:1]};
      end else begin
        pixel <= PIX_WHITE;
      end
    end
  end

`ifdef SCANOUT_FRAME_COUNT_EN
  localparam cnt_t VB_LINE = cnt_t'(V_ACTIVE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else begin
      vblank_start <= (h_cnt == '0) && (v_cnt == VB_LINE);
      if (vblank_start[0]) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_screen_scanout.sv
// Directed bench for screen_scanout with a short vertical raster so whole frames fit
// a small cycle budget; the framebuffer model answers fb_rd one clk later.
module tb_screen_scanout;

  localparam int H_TOT  = 800;
  localparam int V_TOT  = 11;
  localparam int V_ACT  = 6;
  localparam int X_OFF  = 64;
  localparam int Y_OFF  = 3;
  localparam int FRAME  = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] fb_address;
  logic        fb_rd;
  logic [15:0] fb_data;
  logic        pixel, de, hsync_n, vsync_n;
`ifdef SCANOUT_FRAME_COUNT_EN
  logic [15:0] frame_count;
  logic [0:0]  vblank_start;
`endif

  always #5 clk = ~clk;

  screen_scanout #(
    .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_ACTIVE (V_ACT), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .X_OFFSET (X_OFF), .Y_OFFSET (Y_OFF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fb_address (fb_address),
    .fb_rd      (fb_rd),
    .fb_data    (fb_data),
    .pixel      (pixel),
    .de         (de),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n)
`ifdef SCANOUT_FRAME_COUNT_EN
    ,
    .frame_count  (frame_count),
    .vblank_start (vblank_start)
`endif
  );

  logic [15:0] fb_mem [0:8191];

  // Data is only meaningful the clk after fb_rd; otherwise drive junk.
  always @(posedge clk) fb_data <= fb_rd ? fb_mem[fb_address] : 16'($urandom);

  int checks = 0, failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int n;
  int err_pix, err_de, err_hs, err_vs, err_rd, err_addr;
  int hs_low, vs_low, de_hi, rd_cnt, ones, first_one_h, last_one_h;
  int hs_first, vs_first, vs_gap, vs_falls, vs_last;
  int exp_hold;
  logic prev_hs, prev_vs;
`ifdef SCANOUT_FRAME_COUNT_EN
  int err_vb, vb_hi;
`endif

  task automatic clear_stats();
    n = 0; err_pix = 0; err_de = 0; err_hs = 0; err_vs = 0; err_rd = 0; err_addr = 0;
    hs_low = 0; vs_low = 0; de_hi = 0; rd_cnt = 0; ones = 0;
    first_one_h = -1; last_one_h = -1; hs_first = -1; vs_first = -1;
    vs_gap = -1; vs_falls = 0; vs_last = -1; exp_hold = 0;
    prev_hs = 1'b1; prev_vs = 1'b1;
`ifdef SCANOUT_FRAME_COUNT_EN
    err_vb = 0; vb_hi = 0;
`endif
  endtask

  // After edge n since release: registered outputs show counter n-1, fb_rd shows counter n.
  task automatic sample();
    int p, hp, vp, hq, vq;
    logic exp_pix, exp_rd, exp_de, exp_hs_n, exp_vs_n;
    logic [15:0] w;
    p = n - 1;
    hp = p % H_TOT;
    vp = (p / H_TOT) % V_TOT;
    hq = n % H_TOT;
    vq = (n / H_TOT) % V_TOT;
    exp_pix = 1'b0;
    if (hp >= X_OFF && hp < X_OFF + 512 && vp >= Y_OFF && vp < Y_OFF + 256) begin
      w = fb_mem[(vp - Y_OFF) * 32 + (hp - X_OFF) / 16];
      exp_pix = w[(hp - X_OFF) % 16];
    end
    exp_de   = (hp < 640) && (vp < V_ACT);
    exp_hs_n = !(hp >= 656 && hp < 752);
    exp_vs_n = !(vp >= 7 && vp < 9);
    exp_rd   = (vq >= Y_OFF) && (vq < Y_OFF + 256) && (hq >= X_OFF - 1) && (hq <= X_OFF + 495)
               && ((hq - (X_OFF - 1)) % 16 == 0);
    if (exp_rd) exp_hold = (vq - Y_OFF) * 32 + (hq - (X_OFF - 1)) / 16;

    if (pixel !== exp_pix) err_pix++;
    if (de !== exp_de) err_de++;
    if (hsync_n !== exp_hs_n) err_hs++;
    if (vsync_n !== exp_vs_n) err_vs++;
    if (fb_rd !== exp_rd) err_rd++;
    if (int'(fb_address) != exp_hold) err_addr++;
`ifdef SCANOUT_FRAME_COUNT_EN
    if (vblank_start[0] !== (hp == 0 && vp == V_ACT)) err_vb++;
    if (vblank_start[0]) vb_hi++;
`endif

    if (!hsync_n) hs_low++;
    if (!vsync_n) vs_low++;
    if (de) de_hi++;
    if (fb_rd) rd_cnt++;
    if (pixel) begin
      ones++;
      if (first_one_h < 0) first_one_h = hp;
      last_one_h = hp;
    end
    if (prev_hs && !hsync_n && hs_first < 0) hs_first = n;
    if (prev_vs && !vsync_n) begin
      if (vs_first < 0) vs_first = n;
      if (vs_last >= 0) vs_gap = n - vs_last;
      vs_last = n;
      vs_falls++;
    end
    prev_hs = hsync_n;
    prev_vs = vsync_n;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    n++;
    sample();
  endtask

  task automatic hold_reset();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_pixel"}, int'(pixel), 0);
    check({pfx, "_de"}, int'(de), 0);
    check({pfx, "_hsync_n"}, int'(hsync_n), 1);
    check({pfx, "_vsync_n"}, int'(vsync_n), 1);
    check({pfx, "_fb_rd"}, int'(fb_rd), 0);
    check({pfx, "_fb_address"}, int'(fb_address), 0);
  endtask

  task automatic check_stream(input string pfx);
    check({pfx, "_pixel_err"}, err_pix, 0);
    check({pfx, "_de_err"}, err_de, 0);
    check({pfx, "_hsync_err"}, err_hs, 0);
    check({pfx, "_vsync_err"}, err_vs, 0);
    check({pfx, "_fb_rd_err"}, err_rd, 0);
    check({pfx, "_fb_addr_err"}, err_addr, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 8192; i++) fb_mem[i] = 16'h0000;
    fb_mem[0] = 16'h0001;
    fb_mem[1] = 16'h8000;
    clear_stats();
    @(negedge clk);
    repeat (4) hold_reset();
    check_reset_outputs("por");

    // Pattern frame up to h=300, v=5, then a 3-clk mid-line reset.
    reset_n = 1'b1;
    repeat (5 * H_TOT + 300) tick();
    check_stream("pat");
    check("pat_ones", ones, 2);
    check("pat_first_one_h", first_one_h, X_OFF);
    check("pat_last_one_h", last_one_h, X_OFF + 31);
    check("pat_hsync_first_fall", hs_first, 657);
    check("pat_de_before_reset", int'(de), 1);
    check("pat_addr_before_reset", int'(fb_address), 78);

    reset_n = 1'b0;
    repeat (3) hold_reset();
    check_reset_outputs("midrst");

    for (int i = 0; i < 8192; i++) fb_mem[i] = 16'($urandom);
    clear_stats();
    reset_n = 1'b1;
    repeat (3 * FRAME) tick();
    check_stream("rand");
    check("rand_hsync_low", hs_low, 3 * 11 * 96);
    check("rand_vsync_low", vs_low, 3 * 2 * H_TOT);
    check("rand_de_high", de_hi, 3 * V_ACT * 640);
    check("rand_fb_rd_pulses", rd_cnt, 3 * 8 * 32);
    check("rand_vsync_first_fall", vs_first, 7 * H_TOT + 1);
    check("rand_vsync_period", vs_gap, FRAME);
    check("rand_vsync_falls", vs_falls, 3);
`ifdef SCANOUT_FRAME_COUNT_EN
    check("vb_pos_err", err_vb, 0);
    check("vb_high_cycles", vb_hi, 3);
    check("frame_count_3", int'(frame_count), 3);
    repeat (1000) tick();
    reset_n = 1'b0;
    hold_reset();
    check("frame_count_rst", int'(frame_count), 0);
    check("vb_rst", int'(vblank_start), 0);
    reset_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
